// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and the fetch-state encoding
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buffer.sv
// rtl/fetch_hold_buffer.sv - parks one fetched instruction while decode is stalled
module fetch_hold_buffer
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            capture_i,
    input  logic [XLEN-1:0] data_i,
    input  logic            release_i,
    output logic [XLEN-1:0] data_o,
    output logic            valid_o
);

    logic [XLEN-1:0] data_q;
    logic            valid_q;

    // Capture wins over release; release only drops the flag, stale data is harmless.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (capture_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end else if (release_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - single-outstanding fetch FSM feeding IF/ID (IFU_PERF_CNT_EN adds perf counters)
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] next_pc,
    input  logic            is_flush,
    input  logic            id_stall,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic [XLEN-1:0] current_pc,
    output logic [XLEN-1:0] IF_ID_pc,
    output logic [XLEN-1:0] IF_ID_inst,
    output logic            IF_ID_valid,
    output logic [XLEN-1:0] perf_fetch_cnt,
    output logic [XLEN-1:0] perf_flush_cnt,
    output logic [XLEN-1:0] perf_stall_cnt
);

    fetch_state_e    state_q;
    logic            req_valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] if_id_pc_q;
    logic [XLEN-1:0] if_id_inst_q;
    logic            if_id_valid_q;

    logic            handshake;
    logic            deliver_wait;
    logic            deliver_hold;
    logic            deliver;
    logic            capture;
    logic            release_hold;
    logic [XLEN-1:0] hold_data;
    logic            hold_valid;

    // req_valid_q is high exactly when the FSM sits in FETCH.
    assign handshake    = req_valid_q && imem_req_ready;
    assign deliver_wait = (state_q == WAIT) && imem_resp_valid && !id_stall && !is_flush;
    assign deliver_hold = (state_q == HOLD) && hold_valid && !id_stall && !is_flush;
    assign deliver      = deliver_wait || deliver_hold;
    assign capture      = (state_q == WAIT) && imem_resp_valid && id_stall && !is_flush;
    assign release_hold = (state_q == HOLD) && (is_flush || !id_stall);

    fetch_hold_buffer u_hold (
        .clk       (clk),
        .reset     (reset),
        .capture_i (capture),
        .data_i    (imem_resp_data),
        .release_i (release_hold),
        .data_o    (hold_data),
        .valid_o   (hold_valid)
    );

    // Fetch FSM; the request valid is registered alongside the state it decodes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            req_valid_q <= 1'b1;
        end else if (is_flush) begin
            // A response arriving in DRAIN retires the only outstanding request,
            // so leaving DRAIN then is required even when a new flush lands.
            case (state_q)
                FETCH: begin
                    state_q     <= handshake ? DRAIN : FETCH;
                    req_valid_q <= !handshake;
                end
                WAIT, DRAIN: begin
                    state_q     <= imem_resp_valid ? FETCH : DRAIN;
                    req_valid_q <= imem_resp_valid;
                end
                default: begin
                    state_q     <= FETCH;
                    req_valid_q <= 1'b1;
                end
            endcase
        end else begin
            case (state_q)
                FETCH: if (handshake) begin
                    state_q     <= WAIT;
                    req_valid_q <= 1'b0;
                end
                WAIT: if (imem_resp_valid) begin
                    state_q     <= id_stall ? HOLD : FETCH;
                    req_valid_q <= !id_stall;
                end
                HOLD: if (!id_stall) begin
                    state_q     <= FETCH;
                    req_valid_q <= 1'b1;
                end
                default: if (imem_resp_valid) begin
                    state_q     <= FETCH;
                    req_valid_q <= 1'b1;
                end
            endcase
        end
    end

    // PC and IF/ID: flush clears, delivery advances, otherwise bubble unless decode stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_inst_q  <= NOP_INST;
            if_id_valid_q <= 1'b0;
        end else if (is_flush) begin
            pc_q          <= next_pc;
            if_id_pc_q    <= '0;
            if_id_inst_q  <= NOP_INST;
            if_id_valid_q <= 1'b0;
        end else if (deliver) begin
            pc_q          <= next_pc;
            if_id_pc_q    <= pc_q;
            if_id_inst_q  <= deliver_wait ? imem_resp_data : hold_data;
            if_id_valid_q <= 1'b1;
        end else if (!id_stall) begin
            if_id_inst_q  <= NOP_INST;
            if_id_valid_q <= 1'b0;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [XLEN-1:0] fetch_cnt_q;
    logic [XLEN-1:0] flush_cnt_q;
    logic [XLEN-1:0] stall_cnt_q;

    // Event counters; they wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (deliver)  fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (is_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
            if (id_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_fetch_cnt = '0;
    assign perf_flush_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign current_pc     = pc_q;
    assign IF_ID_pc       = if_id_pc_q;
    assign IF_ID_inst     = if_id_inst_q;
    assign IF_ID_valid    = if_id_valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - randomized bench with program-order fetch reference model
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] START_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic [31:0] next_pc;
    logic        is_flush;
    logic        id_stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] current_pc;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_inst;
    logic        IF_ID_valid;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
    logic [31:0] perf_stall_cnt;
    logic [31:0] flush_target;

    instruction_fetch_unit #(.RESET_PC(START_PC)) dut (
        .clk             (clk),
        .reset           (reset),
        .next_pc         (next_pc),
        .is_flush        (is_flush),
        .id_stall        (id_stall),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .current_pc      (current_pc),
        .IF_ID_pc        (IF_ID_pc),
        .IF_ID_inst      (IF_ID_inst),
        .IF_ID_valid     (IF_ID_valid),
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_flush_cnt  (perf_flush_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Branch predictor stand-in: sequential fetch, or the redirect target on a flush.
    always_comb next_pc = is_flush ? flush_target : current_pc + 32'd4;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        if (addr == 32'h0000_0010) return 32'hDEAD_BEEF;
        return {addr[15:0], addr[31:16]} ^ 32'h5A5A_1234;
    endfunction

    // Reference model: architectural fetch pointer, a fetched-but-undelivered
    // instruction, the one memory transaction in flight, and event counts.
    logic [31:0] m_pc, m_if_pc, m_if_inst, m_data, m_addr;
    logic        m_if_valid, m_avail, m_busy, m_stale;
    int          m_lat;
    logic [31:0] m_fetch, m_flush, m_stall;

    task automatic model_reset();
        m_pc = START_PC; m_if_pc = '0; m_if_inst = NOP; m_if_valid = 1'b0;
        m_avail = 1'b0; m_busy = 1'b0; m_stale = 1'b0; m_lat = 0;
        m_data = '0; m_addr = '0;
        m_fetch = '0; m_flush = '0; m_stall = '0;
    endtask

    task automatic run_cycle(input int stall_pct, input int flush_pct,
                             input int ready_pct, input int max_lat, input logic rst);
        logic reqv;
        logic acc;
        logic resp;
        @(negedge clk);
        cyc++;
        reset           = rst;
        id_stall        = ($urandom % 100) < stall_pct;
        is_flush        = ($urandom % 100) < flush_pct;
        flush_target    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
        imem_req_ready  = ($urandom % 100) < ready_pct;
        imem_resp_valid = m_busy && (m_lat == 1);
        imem_resp_data  = imem_resp_valid ? mem_data(m_addr) : $urandom;
        #1;

        reqv = !m_busy && !m_avail;
        check("req_valid", {31'd0, imem_req_valid}, {31'd0, reqv});
        if (reqv) check("req_addr", imem_req_addr, m_pc);
        check("current_pc", current_pc, m_pc);
        check("if_id_valid", {31'd0, IF_ID_valid}, {31'd0, m_if_valid});
        check("if_id_inst", IF_ID_inst, m_if_inst);
        check("if_id_pc", IF_ID_pc, m_if_pc);
`ifdef IFU_PERF_CNT_EN
        check("perf_fetch", perf_fetch_cnt, m_fetch);
        check("perf_flush", perf_flush_cnt, m_flush);
        check("perf_stall", perf_stall_cnt, m_stall);
`else
        check("perf_fetch", perf_fetch_cnt, 32'd0);
        check("perf_flush", perf_flush_cnt, 32'd0);
        check("perf_stall", perf_stall_cnt, 32'd0);
`endif

        acc  = reqv && imem_req_ready;
        resp = imem_resp_valid;
        if (rst) begin
            model_reset();
        end else begin
            if (id_stall) m_stall++;
            if (resp) begin
                m_busy = 1'b0;
                if (!m_stale && !is_flush) begin
                    m_avail = 1'b1;
                    m_data  = mem_data(m_addr);
                end
            end else if (m_busy) begin
                m_lat--;
                if (is_flush) m_stale = 1'b1;
            end
            if (acc) begin
                m_busy  = 1'b1;
                m_stale = is_flush;
                m_addr  = m_pc;
                m_lat   = $urandom_range(1, max_lat);
            end
            if (is_flush) begin
                m_flush++;
                m_pc = flush_target; m_avail = 1'b0;
                m_if_pc = '0; m_if_inst = NOP; m_if_valid = 1'b0;
            end else if (!id_stall) begin
                if (m_avail) begin
                    m_if_pc = m_pc; m_if_inst = m_data; m_if_valid = 1'b1;
                    m_pc = m_pc + 32'd4; m_avail = 1'b0;
                    m_fetch++;
                end else begin
                    m_if_inst = NOP; m_if_valid = 1'b0;
                end
            end
        end
    endtask

    typedef struct {
        int stall_pct;
        int flush_pct;
        int ready_pct;
        int max_lat;
        int cycles;
        int reset_pct;
    } phase_t;

    phase_t phases[6];

    initial begin
        phases[0] = '{0,  0,  100, 1, 20,  0};
        phases[1] = '{0,  0,  0,   1, 6,   0};
        phases[2] = '{40, 0,  70,  3, 300, 0};
        phases[3] = '{30, 10, 70,  3, 600, 1};
        phases[4] = '{50, 25, 50,  3, 600, 1};
        phases[5] = '{20, 5,  100, 1, 200, 0};

        reset = 1'b1; is_flush = 1'b0; id_stall = 1'b0; flush_target = '0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        repeat (2) @(posedge clk);
        model_reset();
        run_cycle(0, 0, 0, 1, 1'b1);

        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < phases[p].cycles; c++) begin
                run_cycle(phases[p].stall_pct, phases[p].flush_pct, phases[p].ready_pct,
                          phases[p].max_lat, ($urandom % 100) < phases[p].reset_pct);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
